decoder_scan: RTL and testbench
===============================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 3: select/index width in bits.
REQ-002 Parameter OUT_N, default 8: number of one-hot outputs; legal range 2..2^SEL_W.
REQ-003 Parameter DIV, default 4: scan prescaler period in clock cycles; legal range 1..65535.
REQ-004 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port en  input  1: advance/update enable; 0 freezes all state.
REQ-007 Port mode  input  1: 0 = direct decode, 1 = auto-scan.
REQ-008 Port sel  input  SEL_W: direct-mode select value.
REQ-009 Port out  output  OUT_N: registered one-hot (or all-zero) decode result.
REQ-010 Port idx  output  SEL_W: registered index currently decoded.
REQ-011 Port err  output  1: registered flag, 1 while the direct-mode index is out of range (>= OUT_N).
REQ-012 Port wrap  output  1: one-cycle pulse when the scan index wraps from OUT_N-1 to 0.

Function
REQ-013 The state machine SHALL have three states: IDLE, DIRECT, SCAN.
REQ-014 IDLE: out=0, idx=0, err=0, wrap=0; with en=1 go to DIRECT if mode=0, else to SCAN; with en=0 stay.
REQ-015 DIRECT with en=1: on each edge, idx<=sel; out<=one-hot(sel) if sel<OUT_N, else out<=0 and err<=1; err<=0 for in-range sel; latency is exactly 1 cycle.
REQ-016 SCAN with en=1: the prescaler counts 0..DIV-1; at count DIV-1 (the tick), the prescaler returns to 0 and idx<=idx+1, wrapping to 0 after OUT_N-1; out always equals one-hot(idx) registered.
REQ-017 DIV=1 SHALL make idx advance on every enabled cycle.
REQ-018 wrap SHALL be 1 for exactly the one cycle in which idx is 0 immediately after a tick from OUT_N-1; wrap is 0 in every other cycle and state.
REQ-019 en=0 in DIRECT or SCAN SHALL hold state, prescaler, idx, out and err unchanged, and SHALL force wrap=0.
REQ-020 A mode change with en=1 SHALL switch state (DIRECT<->SCAN) at that edge and clear the prescaler to 0.
REQ-021 On entry to SCAN, scanning SHALL continue from the current idx, or from 0 if idx>=OUT_N; err<=0.
REQ-022 On entry to DIRECT, the edge SHALL perform a normal direct decode of sel (REQ-015).
REQ-023 In SCAN, err SHALL remain 0 and sel SHALL be ignored.
REQ-024 The prescaler SHALL be sized ceil(log2(DIV)) bits (minimum 1) and SHALL never exceed DIV-1.
REQ-025 The one-hot encoding SHALL use out[k]=1 for index k, with all other bits 0.

Reset
REQ-026 rst=1 at an edge SHALL force state=IDLE, out=0, idx=0, err=0, wrap=0 and prescaler=0, regardless of en, mode or sel.
REQ-027 A reset asserted mid-scan or mid-decode SHALL take priority over all other updates; after release, behaviour SHALL restart per REQ-014.
REQ-028 No output SHALL depend combinationally on any input.

Verification
REQ-029 Defaults, rst 2 cycles, then en=1, mode=0, sel=0..7 stepped every cycle -> out one cycle later = 0x01,0x02,...,0x80; idx tracks sel; err=0.
REQ-030 OUT_N=6, SEL_W=3, DIRECT mode, sel=6 then 7 then 2 -> out=0x00 with err=1 for two cycles, then out=0x04 with err=0, idx=2.
REQ-031 Defaults, en=1, mode=1 from reset -> idx=0 for the first 4 cycles in SCAN, then advances every 4 cycles 0..7,0; wrap=1 for the single cycle idx returns to 0.
REQ-032 SCAN at idx=3 with prescaler=2, en=0 for 10 cycles, then en=1 -> idx stays 3 during the hold and advances to 4 after 2 further enabled cycles; wrap stays 0 throughout.
REQ-033 DIV=1, OUT_N=5, SCAN -> idx cycles 0,1,2,3,4,0 on consecutive cycles; wrap pulses every 5th cycle.
REQ-034 rst asserted for 1 cycle during SCAN at idx=5 -> the next cycle shows out=0, idx=0, wrap=0, state IDLE; with en=1, mode=1 scanning restarts from 0.

Source files
------------

// File: rtl/decoder_scan.sv
// One-hot decoder with a direct-select mode and a prescaled auto-scan mode.
// All outputs are registered; wrap pulses for one cycle when the scan index rolls over.
module decoder_scan #(
  parameter int unsigned SEL_W = 3,
  parameter int unsigned OUT_N = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic [OUT_N-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             err,
  output logic             wrap
);

  localparam int unsigned      PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PresLast = PW'(DIV - 1);
  localparam logic [SEL_W-1:0] IdxLast  = SEL_W'(OUT_N - 1);

  typedef enum logic [1:0] {StIdle, StDirect, StScan} state_e;

  state_e           state_q, state_d;
  logic [OUT_N-1:0] out_q, out_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [PW-1:0]    presc_q, presc_d;

  function automatic logic [OUT_N-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_N-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < OUT_N; k++) begin
      if (i == SEL_W'(k)) v[k] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic in_range(input logic [SEL_W-1:0] i);
    return 32'(i) < OUT_N;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      unique case (state_q)
        StIdle:   state_d = mode ? StScan : StDirect;
        StDirect: if (mode) state_d = StScan;
        StScan:   if (!mode) state_d = StDirect;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    out_d   = out_q;
    idx_d   = idx_q;
    err_d   = err_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (en) begin
      unique case (state_d)
        StDirect: begin
          presc_d = '0;
          idx_d   = sel;
          if (in_range(sel)) begin
            out_d = onehot(sel);
            err_d = 1'b0;
          end else begin
            out_d = '0;
            err_d = 1'b1;
          end
        end
        StScan: begin
          err_d = 1'b0;
          if (state_q != StScan) begin
            // Entering scan: resume from the held index if it is legal.
            presc_d = '0;
            idx_d   = in_range(idx_q) ? idx_q : '0;
            out_d   = onehot(idx_d);
          end else if (presc_q == PresLast) begin
            presc_d = '0;
            if (idx_q == IdxLast) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
            out_d = onehot(idx_d);
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign err  = err_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Scoreboard bench for decoder_scan: three parameterisations share stimulus, expected
// responses are queued per edge and a monitor compares them just after each rising edge.
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode;
  logic [2:0] sel;
  logic [7:0] out0;
  logic [5:0] out1;
  logic [4:0] out2;
  logic [2:0] idx0, idx1, idx2;
  logic       err0, err1, err2, wrap0, wrap1, wrap2;

  always #5 clk = ~clk;

  decoder_scan #(.SEL_W(3), .OUT_N(8), .DIV(4)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .out(out0), .idx(idx0), .err(err0), .wrap(wrap0)
  );
  decoder_scan #(.SEL_W(3), .OUT_N(6), .DIV(4)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .out(out1), .idx(idx1), .err(err1), .wrap(wrap1)
  );
  decoder_scan #(.SEL_W(3), .OUT_N(5), .DIV(1)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .out(out2), .idx(idx2), .err(err2), .wrap(wrap2)
  );

  typedef struct {
    int         dut;
    string      nm;
    logic [7:0] o;
    logic [2:0] ix;
    logic       e;
    logic       w;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [7:0] oh(input int i);
    logic [7:0] v;
    v = 8'd1 << i;
    return v;
  endfunction

  task automatic push(input int d, input string nm, input logic [7:0] o,
                      input logic [2:0] ix, input logic e, input logic w);
    exp_t x;
    x.dut = d;
    x.nm  = nm;
    x.o   = o;
    x.ix  = ix;
    x.e   = e;
    x.w   = w;
    q.push_back(x);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push_zero(input string nm);
    for (int d = 0; d < 3; d++) push(d, nm, 8'h00, 3'd0, 1'b0, 1'b0);
  endtask

  // Expected scan outputs k enabled edges after scan entry from idx 0.
  task automatic scan_exp(input int k, input bit hold);
    int i0, i1, i2;
    i0 = (k / 4) % 8;
    i1 = (k / 4) % 6;
    i2 = k % 5;
    push(0, "scan_d0", oh(i0), 3'(i0), 1'b0, logic'(!hold && k > 0 && k % 4 == 0 && i0 == 0));
    push(1, "scan_d1", oh(i1), 3'(i1), 1'b0, logic'(!hold && k > 0 && k % 4 == 0 && i1 == 0));
    push(2, "scan_d2", oh(i2), 3'(i2), 1'b0, logic'(!hold && k > 0 && k % 5 == 0));
  endtask

  // Monitor
  initial begin
    exp_t       x;
    logic [7:0] a_o;
    logic [2:0] a_ix;
    logic       a_e, a_w;
    forever begin
      @(posedge clk);
      #1;
      while (q.size() > 0) begin
        x = q.pop_front();
        case (x.dut)
          0:       begin a_o = out0;          a_ix = idx0; a_e = err0; a_w = wrap0; end
          1:       begin a_o = {2'b00, out1}; a_ix = idx1; a_e = err1; a_w = wrap1; end
          default: begin a_o = {3'b000, out2}; a_ix = idx2; a_e = err2; a_w = wrap2; end
        endcase
        n_vec++;
        if (a_o !== x.o || a_ix !== x.ix || a_e !== x.e || a_w !== x.w) begin
          n_bad++;
          $display("FAIL %s dut%0d @%0t: got out=%h idx=%0d err=%b wrap=%b, want out=%h idx=%0d err=%b wrap=%b",
                   x.nm, x.dut, $time, a_o, a_ix, a_e, a_w, x.o, x.ix, x.e, x.w);
        end
      end
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0; sel = 3'd0;
    step();
    repeat (2) begin push_zero("reset"); step(); end
    rst = 1'b0; sel = 3'd3;
    push_zero("idle_hold"); step();

    en = 1'b1; mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      push(0, "direct_d0", oh(s), 3'(s), 1'b0, 1'b0);
      push(1, "direct_d1", (s < 6) ? oh(s) : 8'h00, 3'(s), logic'(s >= 6), 1'b0);
      step();
    end
    sel = 3'd6; push(0, "oor6_d0", 8'h40, 3'd6, 1'b0, 1'b0); push(1, "oor6", 8'h00, 3'd6, 1'b1, 1'b0); step();
    sel = 3'd7; push(0, "oor7_d0", 8'h80, 3'd7, 1'b0, 1'b0); push(1, "oor7", 8'h00, 3'd7, 1'b1, 1'b0); step();
    sel = 3'd2; push(0, "back_d0", 8'h04, 3'd2, 1'b0, 1'b0); push(1, "back_in", 8'h04, 3'd2, 1'b0, 1'b0); step();

    en = 1'b0; sel = 3'd5;
    repeat (2) begin
      push(0, "direct_hold", 8'h04, 3'd2, 1'b0, 1'b0);
      push(1, "direct_hold", 8'h04, 3'd2, 1'b0, 1'b0);
      step();
    end

    en = 1'b1; sel = 3'd7;
    push(0, "pre_scan", 8'h80, 3'd7, 1'b0, 1'b0); push(1, "pre_scan", 8'h00, 3'd7, 1'b1, 1'b0); step();
    mode = 1'b1;
    for (int e = 0; e < 4; e++) begin
      push(0, "scan_entry", 8'h80, 3'd7, 1'b0, 1'b0);
      push(1, "scan_entry_oor", 8'h01, 3'd0, 1'b0, 1'b0);
      step();
    end
    push(0, "scan_wrap", 8'h01, 3'd0, 1'b0, 1'b1); push(1, "scan_adv", 8'h02, 3'd1, 1'b0, 1'b0); step();
    push(0, "wrap_end", 8'h01, 3'd0, 1'b0, 1'b0); push(1, "scan_hold", 8'h02, 3'd1, 1'b0, 1'b0); step();

    mode = 1'b0; sel = 3'd3;
    push(0, "scan_to_dir", 8'h08, 3'd3, 1'b0, 1'b0); push(1, "scan_to_dir", 8'h08, 3'd3, 1'b0, 1'b0); step();
    mode = 1'b1; sel = 3'd6;
    for (int e = 0; e < 4; e++) begin
      push(0, "dir_to_scan", 8'h08, 3'd3, 1'b0, 1'b0);
      push(1, "dir_to_scan", 8'h08, 3'd3, 1'b0, 1'b0);
      step();
    end
    push(0, "presc_clear", 8'h10, 3'd4, 1'b0, 1'b0); push(1, "presc_clear", 8'h10, 3'd4, 1'b0, 1'b0); step();

    rst = 1'b1; sel = 3'd5;
    push_zero("reset_mid"); step();
    rst = 1'b0;
    for (int k = 0; k <= 46; k++) begin scan_exp(k, 1'b0); step(); end
    en = 1'b0;
    repeat (10) begin scan_exp(46, 1'b1); step(); end
    en = 1'b1;
    for (int k = 47; k <= 53; k++) begin scan_exp(k, 1'b0); step(); end

    rst = 1'b1;
    push_zero("rst_scan"); step();
    rst = 1'b0;
    for (int k = 0; k <= 5; k++) begin scan_exp(k, 1'b0); step(); end

    step();
    step();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
